// File: rtl/multi_transfer_seq_pkg.sv
// Shared definitions for the Thumb-16 multiple-register transfer sequencer:
// opcode match constants, FSM state encoding, transfer kinds and fixed register indices.
package multi_transfer_seq_pkg;

    // Opcode match patterns on the top bits of the 16-bit instruction
    localparam logic [4:0] OP_STM  = 5'b11000;    // instr16[15:11]
    localparam logic [4:0] OP_LDM  = 5'b11001;    // instr16[15:11]
    localparam logic [6:0] OP_PUSH = 7'b1011010;  // instr16[15:9]
    localparam logic [6:0] OP_POP  = 7'b1011110;  // instr16[15:9]

    localparam int SP_IDX = 13;
    localparam int LR_IDX = 14;
    localparam int PC_IDX = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        K_STM  = 2'd0,
        K_LDM  = 2'd1,
        K_PUSH = 2'd2,
        K_POP  = 2'd3
    } kind_t;

endpackage

// File: rtl/multi_transfer_seq_if.sv
// Data-memory transfer channel between the sequencer (master) and memory (slave).
// A transfer completes in any cycle where xfer_valid and xfer_ready are both high.
interface multi_transfer_seq_if #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 4
);
    logic              xfer_valid;
    logic              xfer_ready;
    logic [ADDR_W-1:0] xfer_addr;
    logic [IDX_W-1:0]  xfer_idx;
    logic              xfer_load;

    modport master (
        output xfer_valid,
        output xfer_addr,
        output xfer_idx,
        output xfer_load,
        input  xfer_ready
    );

    modport slave (
        input  xfer_valid,
        input  xfer_addr,
        input  xfer_idx,
        input  xfer_load,
        output xfer_ready
    );
endinterface

// File: rtl/multi_transfer_seq_reglist_prio_enc.sv
// Lowest-set-bit encoder over a 16-bit register list: index, one-hot of that bit
// (used as the clear mask once the transfer is accepted) and an any-set flag.
module reglist_prio_enc (
    input  logic [15:0] list,
    output logic [3:0]  idx,
    output logic [15:0] onehot,
    output logic        any
);

    // NOTE: every variable written in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (list[i]) idx = 4'(i);
        end
    end

    // Two's-complement trick isolates the lowest set bit
    assign onehot = list & (~list + 16'd1);
    assign any    = |list;

endmodule

// File: rtl/multi_transfer_seq.sv
// Thumb-16 STMIA/LDMIA/PUSH/POP sequencer: walks the register list issuing one memory
// transfer per accepted handshake, then performs base/SP writeback; stalls decode throughout.
module multi_transfer_seq
    import multi_transfer_seq_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [15:0]          instr16,
    input  logic [ADDR_W-1:0]    rn_value,
    input  logic [ADDR_W-1:0]    sp_value,
    multi_transfer_seq_if.master bus,
    output logic                 wb_en,
    output logic [IDX_W-1:0]     wb_idx,
    output logic [ADDR_W-1:0]    wb_value,
    output logic                 pc_load,
    output logic                 pipe_stall,
    output logic                 done
);

    state_t            state, state_nxt;
    kind_t             kind;
    logic [15:0]       list;
    logic [2:0]        rn_idx;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] end_val;
    logic [4:0]        xfer_cnt;
    logic              wb_skip;
    logic              pc_bit;

    // Instruction decode, only consumed in IDLE
    logic        dec_ok;
    kind_t       dec_kind;
    logic [15:0] dec_list;

    always_comb begin
        dec_ok   = 1'b1;
        dec_kind = K_STM;
        dec_list = {8'b0, instr16[7:0]};
        if (instr16[15:11] == OP_STM) begin
            dec_kind = K_STM;
        end else if (instr16[15:11] == OP_LDM) begin
            dec_kind = K_LDM;
        end else if (instr16[15:9] == OP_PUSH) begin
            dec_kind         = K_PUSH;
            dec_list[LR_IDX] = instr16[8];
        end else if (instr16[15:9] == OP_POP) begin
            dec_kind         = K_POP;
            dec_list[PC_IDX] = instr16[8];
        end else begin
            dec_ok = 1'b0;
        end
    end

    // Register count and the 4*n byte span, evaluated in SETUP
    logic [4:0]        pop_cnt;
    logic [ADDR_W-1:0] span;

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < 16; i++) begin
            pop_cnt = pop_cnt + 5'(list[i]);
        end
    end

    assign span = ADDR_W'({pop_cnt, 2'b00});

    logic [3:0]  enc_idx;
    logic [15:0] enc_onehot;
    logic        enc_any;

    reglist_prio_enc u_prio_enc (
        .list   (list),
        .idx    (enc_idx),
        .onehot (enc_onehot),
        .any    (enc_any)
    );

    logic [15:0] list_after;
    logic        is_load;
    logic        is_stack;

    assign list_after = list & ~enc_onehot;
    assign is_load    = (kind == K_LDM) || (kind == K_POP);
    assign is_stack   = (kind == K_PUSH) || (kind == K_POP);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    logic              xfer_valid_c;
    logic [ADDR_W-1:0] xfer_addr_c;
    logic [IDX_W-1:0]  xfer_idx_c;
    logic              xfer_load_c;

    always_comb begin
        state_nxt    = state;
        xfer_valid_c = 1'b0;
        xfer_addr_c  = '0;
        xfer_idx_c   = '0;
        xfer_load_c  = 1'b0;
        wb_en        = 1'b0;
        wb_idx       = '0;
        wb_value     = '0;
        pc_load      = 1'b0;
        done         = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start && dec_ok) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                state_nxt = enc_any ? ST_XFER : ST_WB;
            end
            ST_XFER: begin
                xfer_valid_c = 1'b1;
                xfer_addr_c  = cur_addr;
                xfer_idx_c   = IDX_W'(enc_idx);
                xfer_load_c  = is_load;
                if (bus.xfer_ready && (list_after == 16'd0)) state_nxt = ST_WB;
            end
            ST_WB: begin
                done      = 1'b1;
                wb_en     = !wb_skip && (xfer_cnt != 5'd0);
                wb_idx    = is_stack ? IDX_W'(SP_IDX) : IDX_W'(rn_idx);
                wb_value  = end_val;
                pc_load   = (kind == K_POP) && pc_bit;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Reset is gated in so every output reads 0 while rst_n is held low
    assign pipe_stall = rst_n && ((state != ST_IDLE) || start);

    assign bus.xfer_valid = xfer_valid_c;
    assign bus.xfer_addr  = xfer_addr_c;
    assign bus.xfer_idx   = xfer_idx_c;
    assign bus.xfer_load  = xfer_load_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind     <= K_STM;
            list     <= '0;
            rn_idx   <= '0;
            base     <= '0;
            cur_addr <= '0;
            end_val  <= '0;
            xfer_cnt <= '0;
            wb_skip  <= 1'b0;
            pc_bit   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start && dec_ok) begin
                        kind   <= dec_kind;
                        list   <= dec_list;
                        rn_idx <= instr16[10:8];
                        base   <= ((dec_kind == K_PUSH) || (dec_kind == K_POP)) ? sp_value : rn_value;
                    end
                end
                ST_SETUP: begin
                    xfer_cnt <= pop_cnt;
                    wb_skip  <= (kind == K_LDM) && list[rn_idx];
                    pc_bit   <= list[PC_IDX];
                    // PUSH is a full-descending store: start low, end at the new SP
                    if (kind == K_PUSH) begin
                        cur_addr <= base - span;
                        end_val  <= base - span;
                    end else begin
                        cur_addr <= base;
                        end_val  <= base + span;
                    end
                end
                ST_XFER: begin
                    if (bus.xfer_ready) begin
                        list     <= list_after;
                        cur_addr <= cur_addr + ADDR_W'(4);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_transfer_seq.sv
// Self-checking bench for multi_transfer_seq: table-driven back-to-back instructions
// with ready tied high, plus hand-written stall and mid-transfer reset sequences.
module tb_multi_transfer_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] instr16;
    logic [31:0] rn_value;
    logic [31:0] sp_value;
    logic        wb_en;
    logic [3:0]  wb_idx;
    logic [31:0] wb_value;
    logic        pc_load;
    logic        pipe_stall;
    logic        done;

    int checks = 0;
    int errors = 0;

    multi_transfer_seq_if #(.ADDR_W(32), .IDX_W(4)) bus ();

    multi_transfer_seq #(.ADDR_W(32), .IDX_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .instr16    (instr16),
        .rn_value   (rn_value),
        .sp_value   (sp_value),
        .bus        (bus),
        .wb_en      (wb_en),
        .wb_idx     (wb_idx),
        .wb_value   (wb_value),
        .pc_load    (pc_load),
        .pipe_stall (pipe_stall),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct packed {
        logic [15:0]      instr;
        logic [31:0]      rn;
        logic [31:0]      sp;
        logic [1:0]       n;
        logic [2:0][31:0] addr;
        logic [2:0][3:0]  idx;
        logic             load;
        logic             wb_en;
        logic [3:0]       wb_idx;
        logic [31:0]      wb_value;
        logic             pc_load;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input logic [15:0] instr, input logic [31:0] rn, input logic [31:0] sp,
                                input logic [1:0] n, input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [3:0] i0, input logic [3:0] i1,
                                input logic [3:0] i2, input logic load, input logic wen,
                                input logic [3:0] widx, input logic [31:0] wval, input logic pcl);
        vec_t v;
        v.instr    = instr;
        v.rn       = rn;
        v.sp       = sp;
        v.n        = n;
        v.addr[0]  = a0;
        v.addr[1]  = a1;
        v.addr[2]  = a2;
        v.idx[0]   = i0;
        v.idx[1]   = i1;
        v.idx[2]   = i2;
        v.load     = load;
        v.wb_en    = wen;
        v.wb_idx   = widx;
        v.wb_value = wval;
        v.pc_load  = pcl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Issues one instruction at a negedge and follows it through SETUP, XFER and WB.
    // Ends on the WB negedge so the next call starts back-to-back in the cycle after WB.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        start    = 1'b1;
        instr16  = v.instr;
        rn_value = v.rn;
        sp_value = v.sp;
        #1;
        check({tag, ".stall_on_start"}, 32'(pipe_stall), 32'd1);
        check({tag, ".idle_no_done"}, 32'(done), 32'd0);
        @(negedge clk);
        start   = 1'b0;
        instr16 = 16'h0000;
        check({tag, ".setup_no_xfer"}, 32'(bus.xfer_valid), 32'd0);
        check({tag, ".setup_stall"}, 32'(pipe_stall), 32'd1);
        for (int k = 0; k < int'(v.n); k++) begin
            @(negedge clk);
            check($sformatf("%s.valid%0d", tag, k), 32'(bus.xfer_valid), 32'd1);
            check($sformatf("%s.addr%0d", tag, k), bus.xfer_addr, v.addr[k]);
            check($sformatf("%s.idx%0d", tag, k), 32'(bus.xfer_idx), 32'(v.idx[k]));
            check($sformatf("%s.load%0d", tag, k), 32'(bus.xfer_load), 32'(v.load));
            check($sformatf("%s.no_done%0d", tag, k), 32'(done), 32'd0);
        end
        @(negedge clk);
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".wb_no_xfer"}, 32'(bus.xfer_valid), 32'd0);
        check({tag, ".wb_en"}, 32'(wb_en), 32'(v.wb_en));
        check({tag, ".wb_idx"}, 32'(wb_idx), 32'(v.wb_idx));
        check({tag, ".wb_value"}, wb_value, v.wb_value);
        check({tag, ".pc_load"}, 32'(pc_load), 32'(v.pc_load));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".valid"}, 32'(bus.xfer_valid), 32'd0);
        check({tag, ".addr"}, bus.xfer_addr, 32'd0);
        check({tag, ".idx"}, 32'(bus.xfer_idx), 32'd0);
        check({tag, ".load"}, 32'(bus.xfer_load), 32'd0);
        check({tag, ".wb_en"}, 32'(wb_en), 32'd0);
        check({tag, ".wb_value"}, wb_value, 32'd0);
        check({tag, ".pc_load"}, 32'(pc_load), 32'd0);
        check({tag, ".stall"}, 32'(pipe_stall), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
    endtask

    initial begin
        //              instr     rn            sp            n  a0            a1            a2           i0 i1  i2 ld wen widx wb_value      pcl
        vecs[0] = mk(16'hC20B, 32'h0000_1000, 32'h0,        2'd3, 32'h0000_1000, 32'h0000_1004, 32'h0000_1008, 0, 1, 3, 0, 1, 2,  32'h0000_100C, 0); // STMIA r2!,{r0,r1,r3}
        vecs[1] = mk(16'hB510, 32'h0,        32'h0000_2000, 2'd2, 32'h0000_1FF8, 32'h0000_1FFC, 32'h0,        4, 14, 0, 0, 1, 13, 32'h0000_1FF8, 0); // PUSH {r4,lr}
        vecs[2] = mk(16'hBD01, 32'h0,        32'h0000_1FF8, 2'd2, 32'h0000_1FF8, 32'h0000_1FFC, 32'h0,        0, 15, 0, 1, 1, 13, 32'h0000_2000, 1); // POP {r0,pc}
        vecs[3] = mk(16'hC906, 32'h0000_3000, 32'h0,        2'd2, 32'h0000_3000, 32'h0000_3004, 32'h0,        1, 2,  0, 1, 0, 1,  32'h0000_3008, 0); // LDMIA r1,{r1,r2}
        vecs[4] = mk(16'hC300, 32'h0000_0500, 32'h0,        2'd0, 32'h0,         32'h0,         32'h0,        0, 0,  0, 0, 0, 3,  32'h0000_0500, 0); // STMIA r3!,{} empty
        vecs[5] = mk(16'hC080, 32'hFFFF_FFFC, 32'h0,        2'd1, 32'hFFFF_FFFC, 32'h0,         32'h0,        7, 0,  0, 0, 1, 0,  32'h0000_0000, 0); // STM wraps to 0
        vecs[6] = mk(16'hB401, 32'h0,        32'h0000_0000, 2'd1, 32'hFFFF_FFFC, 32'h0,         32'h0,        0, 0,  0, 0, 1, 13, 32'hFFFF_FFFC, 0); // PUSH {r0} wraps below 0
        vecs[7] = mk(16'hC8A0, 32'h0000_0040, 32'h0,        2'd2, 32'h0000_0040, 32'h0000_0044, 32'h0,        5, 7,  0, 1, 1, 0,  32'h0000_0048, 0); // LDMIA r0!,{r5,r7}

        rst_n          = 1'b0;
        start          = 1'b1;
        instr16        = 16'hC20B;
        rn_value       = 32'h0000_1000;
        sp_value       = 32'h0;
        bus.xfer_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");

        // Back-to-back table run with ready tied high
        for (int v = 0; v < 8; v++) begin
            run_vec(vecs[v], $sformatf("vec%0d", v));
        end
        @(negedge clk);
        check("table_end.no_done", 32'(done), 32'd0);
        check("table_end.stall_dropped", 32'(pipe_stall), 32'd0);

        // STM with ready low for three cycles on the second transfer; a start
        // asserted mid-instruction must be ignored
        start    = 1'b1;
        instr16  = 16'hC20B;
        rn_value = 32'h0000_1000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("stall.addr0", bus.xfer_addr, 32'h0000_1000);
        check("stall.idx0", 32'(bus.xfer_idx), 32'd0);
        @(negedge clk);
        check("stall.addr1", bus.xfer_addr, 32'h0000_1004);
        check("stall.idx1", 32'(bus.xfer_idx), 32'd1);
        bus.xfer_ready = 1'b0;
        start          = 1'b1;
        instr16        = 16'hB510;
        sp_value       = 32'h0000_2000;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            check($sformatf("stall.hold_valid%0d", h), 32'(bus.xfer_valid), 32'd1);
            check($sformatf("stall.hold_addr%0d", h), bus.xfer_addr, 32'h0000_1004);
            check($sformatf("stall.hold_idx%0d", h), 32'(bus.xfer_idx), 32'd1);
            check($sformatf("stall.hold_load%0d", h), 32'(bus.xfer_load), 32'd0);
            check($sformatf("stall.hold_no_done%0d", h), 32'(done), 32'd0);
        end
        bus.xfer_ready = 1'b1;
        start          = 1'b0;
        @(negedge clk);
        check("stall.addr2", bus.xfer_addr, 32'h0000_1008);
        check("stall.idx2", 32'(bus.xfer_idx), 32'd3);
        @(negedge clk);
        check("stall.done_delayed", 32'(done), 32'd1);
        check("stall.wb_en", 32'(wb_en), 32'd1);
        check("stall.wb_idx", 32'(wb_idx), 32'd2);
        check("stall.wb_value", wb_value, 32'h0000_100C);
        @(negedge clk);
        check("stall.ignored_start_valid", 32'(bus.xfer_valid), 32'd0);
        check("stall.ignored_start_stall", 32'(pipe_stall), 32'd0);

        // Reset asserted during the second transfer of POP {r0-r3}
        start    = 1'b1;
        instr16  = 16'hBC0F;
        sp_value = 32'h0000_0100;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rst.addr0", bus.xfer_addr, 32'h0000_0100);
        check("rst.load0", 32'(bus.xfer_load), 32'd1);
        @(negedge clk);
        check("rst.addr1", bus.xfer_addr, 32'h0000_0104);
        check("rst.idx1", 32'(bus.xfer_idx), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst.async");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rst.no_done%0d", c), 32'(done), 32'd0);
            check($sformatf("rst.no_wb%0d", c), 32'(wb_en), 32'd0);
        end
        rst_n = 1'b1;
        run_vec(vecs[1], "rst.restart");
        @(negedge clk);
        check("rst.restart_idle", 32'(pipe_stall), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
